stoch_window_monitor: RTL and testbench



---
 rtl/stoch_window_monitor_pkg.sv | 9 +
 rtl/stoch_window_monitor_if.sv | 16 +
 rtl/stoch_window_monitor_acc.sv | 26 ++
 rtl/stoch_window_monitor.sv | 49 ++++
 tb/tb_stoch_window_monitor.sv | 152 +++++++++++++++
 5 files changed

// File: rtl/stoch_window_monitor_pkg.sv
// stoch_mon_pkg: shared FSM state, mode encodings and window-length sanity check.
package stoch_mon_pkg;
    typedef enum logic {IDLE, RUN} state_t;
    localparam logic MODE_ONESHOT = 1'b0;
    localparam logic MODE_CONT = 1'b1;
    function automatic bit win_len_ok(longint win_len, longint cnt_w);
        return win_len >= 2 && win_len < (longint'(1) << cnt_w);
    endfunction
endpackage

// File: rtl/stoch_window_monitor_if.sv
// stoch_window_monitor_if: control, bitstream and result bundle for the window monitor.
interface stoch_window_monitor_if #(
    parameter int NUM_CH = 4,
    parameter int CNT_W = 16
) ();
    logic start;
    logic stop;
    logic mode;
    logic en;
    logic [NUM_CH-1:0] a;
    logic [NUM_CH*CNT_W-1:0] counts;
    logic valid;
    logic busy;
    modport master (output start, stop, mode, en, a, input counts, valid, busy);
    modport slave (input start, stop, mode, en, a, output counts, valid, busy);
endinterface

// File: rtl/stoch_window_monitor_acc.sv
// stoch_window_acc: per-channel ones accumulator plus the latched window result.
module stoch_window_acc #(
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             clr,
    input  logic             inc,
    input  logic             done,
    input  logic             b,
    output logic [CNT_W-1:0] count
);
    logic [CNT_W-1:0] acc;
    logic [CNT_W-1:0] sum;
    assign sum = acc + CNT_W'(b);
    // The completing sample is folded straight into the latched result.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            acc <= '0;
            count <= '0;
        end else begin
            acc <= clr ? '0 : inc ? sum : acc;
            if (done) count <= sum;
        end
    end
endmodule

// File: rtl/stoch_window_monitor.sv
// stoch_window_monitor: counts 1s per stream over WIN_LEN enabled samples, one-shot or continuous.
module stoch_window_monitor
    import stoch_mon_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W = 16,
    parameter int WIN_LEN = 256
) (
    input logic CLK,
    input logic nRST,
    stoch_window_monitor_if.slave bus
);
    localparam int SW = $clog2(WIN_LEN);
    state_t state, state_nx;
    logic [SW-1:0] smp;
    logic run, inc, done, clr;
    logic [NUM_CH-1:0][CNT_W-1:0] res;
    if (!win_len_ok(WIN_LEN, CNT_W)) begin : g_bad_win
        $error("WIN_LEN must be in 2..2**CNT_W-1");
    end
    // stop beats start, and both beat a completion in the same cycle.
    always_comb begin
        run = state == RUN;
        inc = run && bus.en;
        done = inc && !bus.start && !bus.stop && smp == SW'(WIN_LEN - 1);
        clr = !run || bus.start || done;
        state_nx = !run ? (bus.start && !bus.stop ? RUN : IDLE)
                 : (bus.stop || (done && bus.mode == MODE_ONESHOT)) ? IDLE : RUN;
    end
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state <= IDLE;
            smp <= '0;
            bus.valid <= 1'b0;
        end else begin
            state <= state_nx;
            smp <= clr ? '0 : inc ? smp + 1'b1 : smp;
            bus.valid <= done;
        end
    end
    assign bus.busy = state == RUN;
    assign bus.counts = res;
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        stoch_window_acc #(.CNT_W(CNT_W)) u_acc (
            .CLK(CLK), .nRST(nRST), .clr(clr), .inc(inc), .done(done),
            .b(bus.a[i]), .count(res[i])
        );
    end
endmodule

// File: tb/tb_stoch_window_monitor.sv
// tb_stoch_window_monitor: directed scenarios with a reference-model scoreboard on every valid.
module tb_stoch_window_monitor;
    logic CLK = 1'b0;
    logic nRST = 1'b0;
    int cyc = 0, n_chk = 0, n_fail = 0, n_valid = 0, v_last = -1;
    logic [23:0] exp_q[$];
    int m_acc[3];
    int m_sc = 0;
    bit m_run = 0;

    stoch_window_monitor_if #(.NUM_CH(3), .CNT_W(8)) bus ();
    stoch_window_monitor #(.NUM_CH(3), .CNT_W(8), .WIN_LEN(8)) dut (.CLK(CLK), .nRST(nRST), .bus(bus));

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs and advance the reference window model at that edge.
    task automatic drive(logic rn, logic st, logic sp, logic md, logic e, logic [2:0] av);
        nRST = rn; bus.start = st; bus.stop = sp; bus.mode = md; bus.en = e; bus.a = av;
        @(posedge CLK);
        if (!rn) begin
            m_run = 0; m_sc = 0; m_acc = '{default: 0};
        end else if (!m_run) begin
            if (st && !sp) begin m_run = 1; m_sc = 0; m_acc = '{default: 0}; end
        end else if (sp) begin
            m_run = 0;
        end else if (st) begin
            m_sc = 0; m_acc = '{default: 0};
        end else if (e) begin
            for (int i = 0; i < 3; i++) m_acc[i] += int'(av[i]);
            if (m_sc == 7) begin
                exp_q.push_back({8'(m_acc[2]), 8'(m_acc[1]), 8'(m_acc[0])});
                m_run = md; m_sc = 0; m_acc = '{default: 0};
            end else m_sc++;
        end
        #1;
    endtask

    always @(negedge CLK) begin
        if (bus.valid === 1'b1) begin
            n_valid++;
            v_last = cyc;
            if (exp_q.size() == 0) check("valid_unexpected", 32'(bus.valid), 0);
            else check("counts_sb", 32'(bus.counts), 32'(exp_q.pop_front()));
        end
    end

    initial begin
        int c0, nv0, j, busy_drop;
        int vt[$];
        bus.start = 0; bus.stop = 0; bus.mode = 0; bus.en = 0; bus.a = 0;
        repeat (2) drive(0, 0, 0, 0, 1, 3'b111);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_valid", 32'(bus.valid), 0);
        check("rst_counts", 32'(bus.counts), 0);
        // one-shot window
        drive(1, 1, 0, 0, 1, 3'b111);
        c0 = cyc;
        check("s1_busy_rise", 32'(bus.busy), 1);
        for (int k = 0; k < 8; k++) drive(1, 0, 0, 0, 1, {(k % 2 == 0), 1'b0, 1'b1});
        check("s1_valid", 32'(bus.valid), 1);
        check("s1_busy_fall", 32'(bus.busy), 0);
        check("s1_counts", 32'(bus.counts), 32'h040008);
        drive(1, 0, 0, 0, 1, 3'b111);
        check("s1_valid_cycle", 32'(v_last), 32'(c0 + 8));
        check("s1_valid_once", 32'(n_valid), 1);
        check("s1_valid_low", 32'(bus.valid), 0);
        // enable gaps
        nv0 = n_valid;
        drive(1, 1, 0, 0, 1, 3'b000);
        c0 = cyc;
        j = 0;
        for (int k = 0; k < 11; k++) begin
            if (k == 2 || k == 5 || k == 8) drive(1, 0, 0, 0, 0, 3'b111);
            else begin
                drive(1, 0, 0, 0, 1, {(j % 2 == 0), 1'b0, 1'b1});
                j++;
            end
        end
        drive(1, 0, 0, 0, 0, 3'b000);
        check("s2_valid_cycle", 32'(v_last), 32'(c0 + 11));
        check("s2_valid_once", 32'(n_valid), 32'(nv0 + 1));
        check("s2_counts", 32'(bus.counts), 32'h040008);
        // continuous mode
        drive(1, 1, 0, 1, 1, 3'b001);
        c0 = cyc;
        busy_drop = 0;
        for (int k = 0; k < 24; k++) begin
            drive(1, 0, 0, 1, 1, 3'b001);
            if (bus.valid === 1'b1) vt.push_back(cyc);
            if (bus.busy !== 1'b1) busy_drop++;
        end
        check("s3_valid_n", 32'(vt.size()), 3);
        if (vt.size() == 3) begin
            check("s3_first", 32'(vt[0]), 32'(c0 + 8));
            check("s3_gap1", 32'(vt[1] - vt[0]), 8);
            check("s3_gap2", 32'(vt[2] - vt[1]), 8);
        end
        check("s3_busy_held", 32'(busy_drop), 0);
        check("s3_counts", 32'(bus.counts), 32'h000008);
        drive(1, 0, 1, 1, 1, 3'b001);
        check("s3_stop_busy", 32'(bus.busy), 0);
        // abort after 5 samples, then abort on the completion cycle
        drive(1, 0, 0, 0, 0, 3'b000);
        nv0 = n_valid;
        drive(1, 1, 0, 0, 1, 3'b111);
        repeat (5) drive(1, 0, 0, 0, 1, 3'b111);
        drive(1, 0, 1, 0, 1, 3'b111);
        check("s4_busy", 32'(bus.busy), 0);
        check("s4_counts_kept", 32'(bus.counts), 32'h000008);
        drive(1, 1, 0, 0, 1, 3'b111);
        repeat (7) drive(1, 0, 0, 0, 1, 3'b111);
        drive(1, 0, 1, 0, 1, 3'b111);
        check("s4_done_stop_valid", 32'(bus.valid), 0);
        repeat (2) drive(1, 0, 0, 0, 1, 3'b111);
        check("s4_no_valid", 32'(n_valid), 32'(nv0));
        check("s4_counts_kept2", 32'(bus.counts), 32'h000008);
        // restart mid-window
        drive(1, 1, 0, 0, 1, 3'b111);
        repeat (5) drive(1, 0, 0, 0, 1, 3'b111);
        drive(1, 1, 0, 0, 1, 3'b111);
        c0 = cyc;
        repeat (8) drive(1, 0, 0, 0, 1, 3'b010);
        check("s5_valid", 32'(bus.valid), 1);
        check("s5_counts", 32'(bus.counts), 32'h000800);
        drive(1, 0, 0, 0, 0, 3'b000);
        check("s5_valid_cycle", 32'(v_last), 32'(c0 + 8));
        // reset mid-window, with start held to show reset wins
        drive(1, 1, 0, 1, 1, 3'b111);
        repeat (4) drive(1, 0, 0, 1, 1, 3'b111);
        drive(0, 1, 0, 1, 1, 3'b111);
        check("s6_counts", 32'(bus.counts), 0);
        check("s6_busy", 32'(bus.busy), 0);
        check("s6_valid", 32'(bus.valid), 0);
        nv0 = n_valid;
        repeat (10) drive(1, 0, 0, 1, 1, 3'b111);
        check("s6_idle_busy", 32'(bus.busy), 0);
        check("s6_idle_counts", 32'(bus.counts), 0);
        check("s6_idle_valid", 32'(n_valid), 32'(nv0));
        check("sb_empty", 32'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
